step_sequencer: RTL and testbench

STEP_SEQUENCER -- requirements
Module: step_sequencer

---
 rtl/step_sequencer.sv | 104 ++++++++++
 tb/tb_step_sequencer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/step_sequencer.sv
// Step/direction pulse sequencer: issues a commanded number of step pulses whose
// high and low phases are timed by an external interval timer, tracking signed position.
module step_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [15:0] cmd_steps,
    input  logic [31:0] cmd_half,
    input  logic        cmd_dir,
    input  logic        abort,
    output logic        timer_start,
    output logic [31:0] timer_count,
    input  logic        timer_done,
    output logic        step,
    output logic        dir,
    output logic        busy,
    output logic        done,
    output logic        aborted,
    output logic [31:0] position
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        HIGH_WAIT = 3'd1,
        HIGH_REL  = 3'd2,
        LOW_WAIT  = 3'd3,
        LOW_REL   = 3'd4,
        FINISH    = 3'd5,
        DRAIN     = 3'd6
    } state_t;

    state_t      state;
    logic [15:0] remaining;

    // The *_REL states wait for the timer to drop its done flag before the next
    // interval starts, so any timer latency of one cycle or more is tolerated.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            remaining   <= 16'd0;
            timer_count <= 32'd0;
            dir         <= 1'b0;
            position    <= 32'd0;
            aborted     <= 1'b0;
        end else begin
            aborted <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        remaining   <= cmd_steps;
                        timer_count <= cmd_half;
                        dir         <= cmd_dir;
                        state       <= (cmd_steps == 16'd0) ? FINISH : HIGH_WAIT;
                    end
                end
                HIGH_WAIT: begin
                    if (abort) begin
                        state <= DRAIN;
                    end else if (timer_done) begin
                        state    <= HIGH_REL;
                        position <= dir ? position + 32'd1 : position - 32'd1;
                    end
                end
                HIGH_REL: begin
                    if (abort)
                        state <= DRAIN;
                    else if (!timer_done)
                        state <= LOW_WAIT;
                end
                LOW_WAIT: begin
                    if (abort)
                        state <= DRAIN;
                    else if (timer_done)
                        state <= LOW_REL;
                end
                LOW_REL: begin
                    if (abort) begin
                        state <= DRAIN;
                    end else if (!timer_done) begin
                        remaining <= remaining - 16'd1;
                        state     <= (remaining == 16'd1) ? FINISH : HIGH_WAIT;
                    end
                end
                FINISH: state <= IDLE;
                DRAIN: begin
                    // Let the timer release before reporting the abort.
                    if (!timer_done) begin
                        state   <= IDLE;
                        aborted <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign cmd_ready   = (state == IDLE);
    assign busy        = (state != IDLE);
    assign step        = (state == HIGH_WAIT);
    assign timer_start = (state == HIGH_WAIT) || (state == LOW_WAIT);
    assign done        = (state == FINISH);

endmodule

// File: tb/tb_step_sequencer.sv
// Directed bench for step_sequencer with a behavioural interval timer
// (done rises count+2 cycles after start rises, falls one cycle after start falls).
module tb_step_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [15:0] cmd_steps = 16'd0;
    logic [31:0] cmd_half = 32'd0;
    logic        cmd_dir = 1'b0;
    logic        abort = 1'b0;
    logic        timer_start;
    logic [31:0] timer_count;
    logic        timer_done = 1'b0;
    logic        step;
    logic        dir;
    logic        busy;
    logic        done;
    logic        aborted;
    logic [31:0] position;

    int ncmp = 0;
    int nmis = 0;

    step_sequencer dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_steps(cmd_steps), .cmd_half(cmd_half), .cmd_dir(cmd_dir), .abort(abort),
        .timer_start(timer_start), .timer_count(timer_count), .timer_done(timer_done),
        .step(step), .dir(dir), .busy(busy), .done(done), .aborted(aborted),
        .position(position)
    );

    always #5 clk = ~clk;

    // Timer model
    longint tcnt = 0;
    always @(posedge clk) begin
        if (!timer_start) begin
            tcnt       <= 0;
            timer_done <= 1'b0;
        end else begin
            tcnt <= tcnt + 1;
            if (tcnt + 1 >= longint'(timer_count) + 2)
                timer_done <= 1'b1;
        end
    end

    // Pulse monitor
    int   high_q[$];
    int   low_q[$];
    int   high_run = 0;
    int   low_run = 0;
    bit   pulse_seen = 0;
    logic prev_step = 1'b0;
    int   done_cnt = 0;
    int   abort_cnt = 0;
    int   ts_cnt = 0;

    always @(negedge clk) begin
        if (step) begin
            if (!prev_step) begin
                if (pulse_seen) low_q.push_back(low_run);
                high_run = 1;
            end else begin
                high_run++;
            end
        end else begin
            if (prev_step) begin
                high_q.push_back(high_run);
                high_run   = 0;
                low_run    = 1;
                pulse_seen = 1;
            end else begin
                low_run++;
            end
        end
        prev_step = step;
        if (done)        done_cnt++;
        if (aborted)     abort_cnt++;
        if (timer_start) ts_cnt++;
    end

    task automatic clear_mon();
        high_q.delete();
        low_q.delete();
        high_run   = 0;
        low_run    = 0;
        pulse_seen = 0;
        done_cnt   = 0;
        abort_cnt  = 0;
        ts_cnt     = 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ncmp++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [15:0] s, input logic [31:0] h, input logic d);
        int n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("ready_timeout", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1;
        cmd_steps = s;
        cmd_half  = h;
        cmd_dir   = d;
        @(posedge clk);
        #1;
        // Garbage on the command bus must not disturb the latched move.
        cmd_valid = 1'b0;
        cmd_steps = 16'd1;
        cmd_half  = 32'd77;
        cmd_dir   = ~d;
    endtask

    task automatic wait_idle(input string tag, input logic exp_done, input logic exp_abort);
        logic pd = 1'b0;
        int   n = 0;
        @(negedge clk);
        while (busy && n < 2000) begin
            pd = done;
            @(negedge clk);
            n++;
        end
        chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done_last"}, {31'd0, pd}, {31'd0, exp_done});
        chk({tag, "_aborted"}, {31'd0, aborted}, {31'd0, exp_abort});
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, {31'd0, cmd_ready}, 32'd1);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_step"}, {31'd0, step}, 32'd0);
        chk({tag, "_tstart"}, {31'd0, timer_start}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_aborted"}, {31'd0, aborted}, 32'd0);
        chk({tag, "_pos"}, position, 32'd0);
        chk({tag, "_dir"}, {31'd0, dir}, 32'd0);
        chk({tag, "_tcount"}, timer_count, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int rises;
        int n;
        logic ps;

        // Reset and release
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("in_reset");
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("after_release");

        // Three forward steps, half = 2
        clear_mon();
        issue(16'd3, 32'd2, 1'b1);
        @(negedge clk);
        chk("a_tcount", timer_count, 32'd2);
        chk("a_dir", {31'd0, dir}, 32'd1);
        chk("a_step_first", {31'd0, step}, 32'd1);
        chk("a_ready_busy", {31'd0, cmd_ready}, 32'd0);
        wait_idle("a", 1'b1, 1'b0);
        #1;
        chk("a_npulses", high_q.size(), 32'd3);
        foreach (high_q[i]) chk($sformatf("a_high%0d", i), high_q[i], 32'd5);
        chk("a_ngaps", low_q.size(), 32'd2);
        foreach (low_q[i]) chk($sformatf("a_low%0d", i), low_q[i], 32'd9);
        chk("a_pos", position, 32'd3);
        chk("a_done_cnt", done_cnt, 32'd1);
        chk("a_abort_cnt", abort_cnt, 32'd0);

        // Zero-step move
        clear_mon();
        issue(16'd0, 32'd5, 1'b0);
        @(negedge clk);
        chk("b_done", {31'd0, done}, 32'd1);
        chk("b_busy", {31'd0, busy}, 32'd1);
        chk("b_dir", {31'd0, dir}, 32'd0);
        @(negedge clk);
        chk("b_done_off", {31'd0, done}, 32'd0);
        chk("b_ready", {31'd0, cmd_ready}, 32'd1);
        #1;
        chk("b_no_step", high_q.size(), 32'd0);
        chk("b_no_tstart", ts_cnt, 32'd0);
        chk("b_pos", position, 32'd3);
        chk("b_done_cnt", done_cnt, 32'd1);

        // Reverse through zero with half = 0, then forward back
        clear_mon();
        issue(16'd4, 32'd0, 1'b0);
        wait_idle("c_rev", 1'b1, 1'b0);
        #1;
        chk("c_rev_pos", position, 32'hFFFF_FFFF);
        chk("c_rev_npulses", high_q.size(), 32'd4);
        chk("c_rev_high0", high_q[0], 32'd3);
        chk("c_rev_done_cnt", done_cnt, 32'd1);
        clear_mon();
        issue(16'd1, 32'd0, 1'b1);
        wait_idle("c_fwd", 1'b1, 1'b0);
        #1;
        chk("c_fwd_pos", position, 32'd0);

        // Abort during the second low phase, from a fresh reset
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        clear_mon();
        issue(16'd4, 32'd2, 1'b0);
        rises = 0;
        n = 0;
        ps = 1'b0;
        forever begin
            @(negedge clk);
            if (step && !ps) rises++;
            ps = step;
            n++;
            if ((rises == 2 && !step && timer_start) || n > 500) break;
        end
        chk("d_reach_low_wait", {31'd0, timer_start & ~step}, 32'd1);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        wait_idle("d", 1'b0, 1'b1);
        #1;
        chk("d_pos", position, 32'hFFFF_FFFE);
        chk("d_done_cnt", done_cnt, 32'd0);
        chk("d_abort_cnt", abort_cnt, 32'd1);
        @(negedge clk);
        chk("d_aborted_off", {31'd0, aborted}, 32'd0);

        // Abort on the HIGH_WAIT cycle where the timer is done: no position
        // update, and DRAIN must hold while timer_done is still high.
        clear_mon();
        issue(16'd2, 32'd1, 1'b1);
        n = 0;
        forever begin
            @(negedge clk);
            n++;
            if ((step && timer_done) || n > 500) break;
        end
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        chk("e_drain_busy", {31'd0, busy}, 32'd1);
        chk("e_drain_step", {31'd0, step}, 32'd0);
        chk("e_drain_tstart", {31'd0, timer_start}, 32'd0);
        chk("e_drain_tdone", {31'd0, timer_done}, 32'd1);
        chk("e_drain_aborted", {31'd0, aborted}, 32'd0);
        wait_idle("e", 1'b0, 1'b1);
        #1;
        chk("e_pos", position, 32'hFFFF_FFFE);
        chk("e_abort_cnt", abort_cnt, 32'd1);
        chk("e_done_cnt", done_cnt, 32'd0);

        // Asynchronous reset in the middle of HIGH_WAIT
        clear_mon();
        issue(16'd5, 32'd3, 1'b1);
        n = 0;
        forever begin
            @(negedge clk);
            n++;
            if (step || n > 100) break;
        end
        chk("f_in_high", {31'd0, step}, 32'd1);
        #2 reset = 1'b0;
        #1;
        check_reset_outputs("f_async");
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        chk("f_done_cnt", done_cnt, 32'd0);
        chk("f_abort_cnt", abort_cnt, 32'd0);
        chk("f_busy", {31'd0, busy}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nmis);
        $finish;
    end

endmodule
